booth_ctrl: RTL and testbench
=============================

BOOTH_CTRL -- requirements
Module: booth_ctrl

Interface
REQ-001 Parameter: WIDTH, default 32, operand width in bits (number of Booth iterations).
REQ-002 Parameter: CW, default $clog2(WIDTH+1), iteration counter width.
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 start  in  1  request a new multiplication; sampled only in IDLE.
REQ-006 q0  in  1  current LSB of the Q (multiplier) register.
REQ-007 qm1  in  1  current value of the Q(-1) flip-flop.
REQ-008 ld_m  out  1  load multiplicand register M from its data input.
REQ-009 ld_q  out  1  load Q register from its data input.
REQ-010 clr_a  out  1  clear accumulator A to 0.
REQ-011 clr_qm1  out  1  clear Q(-1) to 0.
REQ-012 ld_a  out  1  load A with the ALU result.
REQ-013 add_sub  out  1  ALU select: 1 = A+M, 0 = A-M.
REQ-014 sft  out  1  arithmetic right shift of the {A,Q,Q(-1)} chain by one bit.
REQ-015 busy  out  1  high in every state except IDLE.
REQ-016 done  out  1  single-cycle completion pulse.
REQ-017 count  out  CW  remaining iterations.

Function
REQ-018 The block shall be a Moore FSM with states IDLE, LOAD, EVAL, ADDSUB, SHIFT and DONE; all strobes shall decode from the state register only, except add_sub, which comes from the registered op bit.
REQ-019 IDLE: all strobes low; start=1 -> LOAD; start=0 -> stay.
REQ-020 LOAD: ld_m=ld_q=clr_a=clr_qm1=1 for one cycle; count<=WIDTH; -> EVAL.
REQ-021 EVAL: no strobes; {q0,qm1}=01 -> op<=1, ADDSUB; 10 -> op<=0, ADDSUB; 00 or 11 -> SHIFT, op unchanged.
REQ-022 ADDSUB: ld_a=1 for one cycle; add_sub=op; -> SHIFT.
REQ-023 SHIFT: sft=1 for one cycle; count<=count-1; count==1 -> DONE, else -> EVAL.
REQ-024 DONE: done=1 for one cycle; count remains 0; -> IDLE unconditionally.
REQ-025 add_sub shall hold op in every state, so it is stable one cycle before and during ld_a.
REQ-026 start outside IDLE shall be ignored with no queuing; start held high through DONE shall launch LOAD on the cycle after the IDLE cycle.
REQ-027 Latency from the start-sampling edge to done high shall be 1 + 2*WIDTH + (number of ADDSUB visits) + 1 cycles, bounded in [2*WIDTH+2, 3*WIDTH+2].
REQ-028 count shall never underflow; the decrement occurs only in SHIFT with count>=1.
REQ-029 busy shall be high in LOAD through DONE inclusive.
REQ-030 ld_a and sft shall never be high in the same cycle, and no strobe other than sft shall be high in SHIFT.

Reset
REQ-031 While rst=1 at a clock edge: state<=IDLE, count<=0, op<=0; all outputs 0 in the following cycle, including busy and done.
REQ-032 rst shall take priority over start and over any in-progress operation; asserting it mid-iteration shall abort the operation with no done pulse.
REQ-033 Datapath registers are not cleared by rst; the next LOAD reinitialises A, Q(-1), M and Q.

Verification
REQ-034 WIDTH=4, q0=0, qm1=0 held, start pulsed at cycle 0 -> LOAD at cycle 1, EVAL/SHIFT alternating cycles 2-9, done=1 at cycle 10 only, ld_a never high, count sequence 4,3,2,1,0.
REQ-035 WIDTH=4, q0=1, qm1=0 held -> 4 ld_a pulses, each with add_sub=0; done at cycle 14.
REQ-036 WIDTH=4, q0=0, qm1=1 held -> 4 ld_a pulses with add_sub=1; done at cycle 14.
REQ-037 Integrated with 32-bit A/Q/M registers and ALU, WIDTH=32: M=-7, Q=6 -> {A,Q}=-42; M=-2147483648, Q=-1 -> +2147483648 (64-bit); M=0, Q=12345 -> 0; check each done within 98 cycles.
REQ-038 Assert rst during ADDSUB of iteration 2 -> next cycle state IDLE, all outputs 0, no done; a fresh start then completes normally.
REQ-039 Pulse start in EVAL and in SHIFT -> no effect on sequence or latency; hold start high continuously -> back-to-back operations with exactly one IDLE cycle between done and LOAD.

Source files
------------

// File: rtl/booth_ctrl.sv
// Booth radix-2 multiplier control unit.
// Moore FSM that sequences an external {A, Q, Q(-1)} datapath through WIDTH
// evaluate/(add|sub)/shift iterations and pulses done on completion.
module booth_ctrl #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CW    = $clog2(WIDTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          q0,
    input  logic          qm1,
    output logic          ld_m,
    output logic          ld_q,
    output logic          clr_a,
    output logic          clr_qm1,
    output logic          ld_a,
    output logic          add_sub,
    output logic          sft,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] count
);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StEval,
        StAddSub,
        StShift,
        StDone
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic            op_q, op_d;

    // State, iteration counter and op bit; reset wins over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            count_q <= '0;
            op_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            op_q    <= op_d;
        end
    end

    // Next-state, counter and op selection.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        op_d    = op_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StLoad;
                end
            end
            StLoad: begin
                count_d = CW'(WIDTH);
                state_d = StEval;
            end
            StEval: begin
                // 01 -> add M, 10 -> subtract M, 00/11 -> shift only.
                unique case ({q0, qm1})
                    2'b01: begin
                        op_d    = 1'b1;
                        state_d = StAddSub;
                    end
                    2'b10: begin
                        op_d    = 1'b0;
                        state_d = StAddSub;
                    end
                    default: state_d = StShift;
                endcase
            end
            StAddSub: begin
                state_d = StShift;
            end
            StShift: begin
                // Guarded so the counter can never wrap below zero.
                if (count_q != '0) begin
                    count_d = count_q - CW'(1);
                end
                if (count_q == CW'(1)) begin
                    state_d = StDone;
                end else begin
                    state_d = StEval;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Moore strobe decode; add_sub follows the registered op bit in every state
    // so the ALU select is settled a cycle before ld_a fires.
    always_comb begin
        ld_m    = 1'b0;
        ld_q    = 1'b0;
        clr_a   = 1'b0;
        clr_qm1 = 1'b0;
        ld_a    = 1'b0;
        sft     = 1'b0;
        busy    = (state_q != StIdle);
        done    = 1'b0;
        add_sub = op_q;
        count   = count_q;
        unique case (state_q)
            StLoad: begin
                ld_m    = 1'b1;
                ld_q    = 1'b1;
                clr_a   = 1'b1;
                clr_qm1 = 1'b1;
            end
            StAddSub: ld_a = 1'b1;
            StShift:  sft  = 1'b1;
            StDone:   done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_booth_ctrl.sv
// Directed bench for booth_ctrl: cycle-exact strobe/count sequences on a
// 4-bit instance and full products on a 32-bit instance driving a datapath model.
module tb_booth_ctrl;

    // Strobe vector bit order: ld_m ld_q clr_a clr_qm1 ld_a add_sub sft busy done
    localparam logic [8:0] VIdle  = 9'b000000000;
    localparam logic [8:0] VLoad  = 9'b111100010;
    localparam logic [8:0] VEval  = 9'b000000010;
    localparam logic [8:0] VAdd   = 9'b000010010;
    localparam logic [8:0] VShift = 9'b000000110;
    localparam logic [8:0] VDone  = 9'b000000011;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    logic exp_op = 1'b0;

    // 4-bit instance
    logic       start4, q0_4, qm1_4;
    logic       ld_m4, ld_q4, clr_a4, clr_qm14, ld_a4, add_sub4, sft4, busy4, done4;
    logic [2:0] count4;
    logic [8:0] outs4;
    assign outs4 = {ld_m4, ld_q4, clr_a4, clr_qm14, ld_a4, add_sub4, sft4, busy4, done4};

    booth_ctrl #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .q0(q0_4), .qm1(qm1_4),
        .ld_m(ld_m4), .ld_q(ld_q4), .clr_a(clr_a4), .clr_qm1(clr_qm14),
        .ld_a(ld_a4), .add_sub(add_sub4), .sft(sft4), .busy(busy4), .done(done4),
        .count(count4)
    );

    // 32-bit instance with a behavioural A/Q/M datapath
    logic        start32;
    logic        ld_m32, ld_q32, clr_a32, clr_qm132, ld_a32, add_sub32, sft32, busy32, done32;
    logic [5:0]  count32;
    logic [31:0] m_in, q_in, m_r, q_r;
    logic [32:0] a_r;    // one guard bit so -M stays representable for M = -2^31
    logic        qm1_r;
    logic [32:0] m_ext;
    assign m_ext = {m_r[31], m_r};

    booth_ctrl #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .start(start32), .q0(q_r[0]), .qm1(qm1_r),
        .ld_m(ld_m32), .ld_q(ld_q32), .clr_a(clr_a32), .clr_qm1(clr_qm132),
        .ld_a(ld_a32), .add_sub(add_sub32), .sft(sft32), .busy(busy32), .done(done32),
        .count(count32)
    );

    always @(posedge clk) begin
        if (ld_m32)   m_r   <= m_in;
        if (ld_q32)   q_r   <= q_in;
        if (clr_a32)  a_r   <= '0;
        if (clr_qm132) qm1_r <= 1'b0;
        if (ld_a32)   a_r   <= add_sub32 ? a_r + m_ext : a_r - m_ext;
        if (sft32) begin
            a_r   <= {a_r[32], a_r[32:1]};
            q_r   <= {a_r[0], q_r[31:1]};
            qm1_r <= q_r[0];
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got hang expected finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [8:0] ev(input logic [8:0] base, input logic op);
        ev = base | (9'(op) << 3);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic step(input string tag, input logic [8:0] base, input int cnt);
        chk({tag, " strobes"}, 64'(outs4), 64'(ev(base, exp_op)));
        chk({tag, " count"}, 64'(count4), 64'(cnt));
    endtask

    // Runs one operation from the start cycle (cycle 0) to the IDLE cycle after done.
    task automatic do_op4(input logic a, input logic b, input logic noise,
                          input logic hold, input int exp_lat);
        q0_4   = a;
        qm1_4  = b;
        start4 = 1'b1;
        cyc    = 0;
        tick();
        start4 = hold;
        step("load", VLoad, 0);
        tick();
        for (int it = 0; it < 4; it++) begin
            step("eval", VEval, 4 - it);
            if (a != b) exp_op = b;
            start4 = noise | hold;
            tick();
            start4 = hold;
            if (a != b) begin
                step("addsub", VAdd, 4 - it);
                tick();
            end
            step("shift", VShift, 4 - it);
            start4 = noise | hold;
            tick();
            start4 = hold;
        end
        step("done", VDone, 0);
        chk("latency", 64'(cyc), 64'(exp_lat));
        tick();
        step("idle", VIdle, 0);
    endtask

    task automatic mul32(input string tag, input logic [31:0] m, input logic [31:0] q,
                         input logic [63:0] exp_p, input int exp_lat);
        int n;
        m_in    = m;
        q_in    = q;
        start32 = 1'b1;
        tick();
        start32 = 1'b0;
        n = 1;
        while (!done32 && n < 200) begin
            tick();
            n++;
        end
        chk({tag, " done seen"}, 64'(done32), 64'd1);
        chk({tag, " latency"}, 64'(n), 64'(exp_lat));
        chk({tag, " within 98"}, 64'(n <= 98), 64'd1);
        chk({tag, " product"}, {a_r[31:0], q_r}, exp_p);
        tick();
        chk({tag, " idle"}, 64'(busy32), 64'd0);
    endtask

    initial begin
        rst = 1'b1; start4 = 1'b0; q0_4 = 1'b0; qm1_4 = 1'b0;
        start32 = 1'b0; m_in = '0; q_in = '0;
        tick();
        tick();
        rst = 1'b0;
        step("reset", VIdle, 0);
        chk("reset busy32", 64'(busy32), 64'd0);
        chk("reset count32", 64'(count32), 64'd0);

        // Shift-only, sub-every-iteration, add-every-iteration
        do_op4(1'b0, 1'b0, 1'b0, 1'b0, 10);
        do_op4(1'b1, 1'b0, 1'b0, 1'b0, 14);
        do_op4(1'b0, 1'b1, 1'b0, 1'b0, 14);
        // start pulses in EVAL/SHIFT must be ignored
        do_op4(1'b0, 1'b0, 1'b1, 1'b0, 10);
        // start held: exactly one IDLE cycle, then the next LOAD
        do_op4(1'b1, 1'b1, 1'b0, 1'b1, 10);
        do_op4(1'b0, 1'b0, 1'b0, 1'b0, 10);

        // Abort during ADDSUB of iteration 2
        q0_4 = 1'b1; qm1_4 = 1'b0; start4 = 1'b1;
        tick();
        start4 = 1'b0;
        tick(); tick();           // EVAL, ADDSUB
        exp_op = 1'b0;
        tick(); tick(); tick();   // SHIFT, EVAL, ADDSUB
        step("abort addsub", VAdd, 3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_op = 1'b0;
        step("abort reset", VIdle, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            step("abort quiet", VIdle, 0);
        end
        do_op4(1'b1, 1'b0, 1'b0, 1'b0, 14);

        mul32("m-7q6", 32'hFFFF_FFF9, 32'd6, 64'hFFFF_FFFF_FFFF_FFD6, 68);
        mul32("mminq-1", 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 67);
        mul32("m0q12345", 32'd0, 32'd12345, 64'd0, 72);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
